// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// A request is accepted in IDLE, waits out LATENCY cycles in BUSY, and its response is held in RESP until consumed.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// BUSY  | latency countdown; the access commits on the edge where cnt==0
// RESP  | response held stable until resp_ready
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        hold_write;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;
  logic [3:0]  hold_be;
  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          addr_err;
  logic          commit;
  logic          mem_we;

  assign idx      = hold_addr[AW+1:2];
  assign addr_err = (hold_addr[1:0] != 2'b00) || (hold_addr[31:AW+2] != '0);
  assign commit   = (state == BUSY) && (cnt == 4'd0);
  assign mem_we   = commit && hold_write && !addr_err;

  // The array has no reset: a reset during BUSY leaves the state machine in IDLE, so a pending write never commits.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (hold_be[b]) mem[idx][8*b +: 8] <= hold_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      hold_write <= 1'b0;
      hold_addr  <= 32'd0;
      hold_wdata <= 32'd0;
      hold_be    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            hold_write <= req_write;
            hold_addr  <= req_addr;
            hold_wdata <= req_wdata;
            hold_be    <= req_be;
            cnt        <= 4'(LATENCY - 1);
            req_ready  <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= addr_err;
            resp_rdata <= (!hold_write && !addr_err) ? mem[idx] : 32'd0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=3 instance for the main tests and a LATENCY=1 instance for back-to-back reads.
module tb_data_mem_responder;
  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic [3:0]  a_req_be;
  logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_be;

  int checks = 0;
  int failures = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Full transaction on dut_a with resp_ready high; checks latency, data, error and the return to IDLE.
  task automatic xact_a(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata,
                        input logic exp_err, input string tag);
    int k;
    @(negedge clk);
    chk({tag, "_req_ready"}, {31'd0, a_req_ready}, 32'd1);
    a_req_valid = 1'b1; a_req_write = w; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_addr = 32'h0000_0000; a_req_wdata = 32'h0BAD_0BAD; a_req_be = 4'h0;
    k = 0;
    while (!a_resp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(LAT_A));
    chk({tag, "_rdata"}, a_resp_rdata, exp_rdata);
    chk({tag, "_err"}, {31'd0, a_resp_err}, {31'd0, exp_err});
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, {31'd0, a_resp_valid}, 32'd0);
  endtask

  task automatic write_b(input logic [31:0] addr, input logic [31:0] wdata);
    int k;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = addr; b_req_wdata = wdata; b_req_be = 4'hF;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    k = 0;
    while (!b_resp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b_write_latency", 32'(k), 32'(LAT_B));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc, n_acc, n_rsp;
    int acc_cyc [2];
    logic [31:0] rsp [2];
    logic acc;

    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0; a_resp_ready = 1;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0; b_resp_ready = 1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("rst_resp_rdata", a_resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, a_resp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Full-word write then read back
    xact_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "wr_full");
    xact_a(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "rd_full");

    // Single byte lane: be[2] is bits 23:16
    xact_a(1'b1, 32'h10, 32'h00AA0000, 4'b0100, 32'h0, 1'b0, "wr_byte2");
    xact_a(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAABEEF, 1'b0, "rd_byte2");

    // Errors and boundaries
    xact_a(1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1, "rd_misaligned");
    xact_a(1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1, "rd_out_of_range");
    xact_a(1'b1, 32'h401, 32'h12345678, 4'hF, 32'h0, 1'b1, "wr_bad_addr");
    xact_a(1'b1, 32'h410, 32'h12345678, 4'hF, 32'h0, 1'b1, "wr_oor_alias");
    xact_a(1'b1, 32'h10, 32'h12345678, 4'h0, 32'h0, 1'b0, "wr_be_zero");
    xact_a(1'b0, 32'h10, 32'h0, 4'h3, 32'hDEAABEEF, 1'b0, "rd_unchanged");
    xact_a(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "wr_last_word");
    xact_a(1'b0, 32'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "rd_last_word");

    // Backpressure in RESP, with a stray request pulse that must be ignored
    a_resp_ready = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h10; a_req_be = 4'hF;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    k = 0;
    while (!a_resp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_latency", 32'(k), 32'(LAT_A));
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h10;
        a_req_wdata = 32'hFFFFFFFF; a_req_be = 4'hF;
      end
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      chk("bp_resp_valid", {31'd0, a_resp_valid}, 32'd1);
      chk("bp_resp_rdata", a_resp_rdata, 32'hDEAABEEF);
      chk("bp_resp_err", {31'd0, a_resp_err}, 32'd0);
      chk("bp_req_ready", {31'd0, a_req_ready}, 32'd0);
    end
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("bp_release_rdata", a_resp_rdata, 32'd0);
    @(posedge clk); #1;
    chk("bp_no_phantom", {31'd0, a_req_ready}, 32'd1);
    xact_a(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAABEEF, 1'b0, "bp_pulse_dropped");

    // Reset mid-BUSY aborts a pending write
    xact_a(1'b1, 32'h20, 32'h11111111, 4'hF, 32'h0, 1'b0, "wr_pre_reset");
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'h22222222; a_req_be = 4'hF;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_req_ready", {31'd0, a_req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("async_rst_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("async_rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    xact_a(1'b0, 32'h20, 32'h0, 4'hF, 32'h11111111, 1'b0, "rd_after_reset");

    // LATENCY=1: back-to-back reads, accepts 3 cycles apart, data in order
    write_b(32'h0, 32'hA0A0A0A0);
    write_b(32'h4, 32'h5B5B5B5B);
    b_req_write = 1'b0; b_req_be = 4'hF; b_req_addr = 32'h0; b_req_valid = 1'b1;
    n_acc = 0; n_rsp = 0; cyc = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; rsp[0] = 32'h0; rsp[1] = 32'h0;
    while (cyc < 40 && n_rsp < 2) begin
      @(negedge clk);
      cyc++;
      acc = b_req_valid && b_req_ready;
      if (b_resp_valid) begin
        rsp[n_rsp] = b_resp_rdata;
        n_rsp++;
      end
      if (acc && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (n_acc == 1) b_req_addr = 32'h4;
        else b_req_valid = 1'b0;
      end
    end
    b_req_valid = 1'b0;
    chk("b2b_accepts", 32'(n_acc), 32'd2);
    chk("b2b_responses", 32'(n_rsp), 32'd2);
    chk("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    chk("b2b_data0", rsp[0], 32'hA0A0A0A0);
    chk("b2b_data1", rsp[1], 32'h5B5B5B5B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
